// File: rtl/instruction_loader.sv
// instruction_loader
//   Boot-time program loader placed in front of the instruction memory.
//   Takes a valid/ready byte stream, assembles 16-bit instructions
//   (high byte first) and writes them to memory from address 0 upwards.
//   The load ends on the terminator word END_WORD (never written) or
//   when the memory is full. finish then stays high until the next start.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high
//   start                    begin a load (honoured in IDLE or DONE only)
//   byte_in / byte_valid     incoming byte stream
//   byte_ready               loader accepts a byte (HI or LO state)
//   instruction_in           memory write data
//   new_instruction_address  memory write address
//   we                       one-cycle write strobe per stored word
//   finish                   load complete, held in DONE
//   busy                     high while loading (HI, LO, WRITE)
//   word_count               words written in the current or last load
//
// state | meaning
// IDLE  | after reset, waiting for start
// HI    | waiting for the high byte of a word
// LO    | waiting for the low byte of a word
// WRITE | single cycle: word is written (or terminator recognised)
// DONE  | load complete, finish high, waiting for start

module instruction_loader #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] END_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [DATA_W-1:0] instruction_in,
    output logic [ADDR_W-1:0] new_instruction_address,
    output logic              we,
    output logic              finish,
    output logic              busy,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [7:0]          hi_q;
    logic [DATA_W-1:0]   word_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [DATA_W-1:0]   word_asm;
    logic                xfer;
    logic                we_d;
    logic                load_start;
    logic                store;

    assign byte_ready = (state_q == S_HI) || (state_q == S_LO);
    assign xfer       = byte_valid && byte_ready;
    assign word_asm   = {hi_q, byte_in};

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        load_start = 1'b0;
        store      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HI;
                    load_start = 1'b1;
                end
            end
            S_HI: begin
                if (xfer) state_d = S_LO;
            end
            S_LO: begin
                if (xfer) begin
                    state_d = S_WRITE;
                    // The strobe is registered, so it is decided here to be
                    // high during the WRITE cycle itself.
                    we_d    = (word_asm != END_WORD);
                end
            end
            S_WRITE: begin
                if (word_q == END_WORD) begin
                    state_d = S_DONE;
                end else begin
                    store   = 1'b1;
                    state_d = (ptr_q == PTR_LAST) ? S_DONE : S_HI;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d    = S_HI;
                    load_start = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                 <= S_IDLE;
            we                      <= 1'b0;
            finish                  <= 1'b0;
            busy                    <= 1'b0;
            instruction_in          <= '0;
            new_instruction_address <= '0;
            word_count              <= '0;
            ptr_q                   <= '0;
            hi_q                    <= '0;
            word_q                  <= '0;
        end else begin
            state_q <= state_d;
            we      <= we_d;
            busy    <= (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WRITE);
            finish  <= (state_d == S_DONE);

            if (state_q == S_HI && xfer) begin
                hi_q <= byte_in;
            end

            if (state_q == S_LO && xfer) begin
                word_q <= word_asm;
                if (we_d) begin
                    instruction_in          <= word_asm;
                    new_instruction_address <= ptr_q;
                end
            end

            if (load_start) begin
                ptr_q      <= '0;
                word_count <= '0;
            end else if (store) begin
                // After the last address the load ends, so the pointer
                // rolling over is never used for a write.
                ptr_q <= ptr_q + 1'b1;
                if (word_count != WC_MAX) begin
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Directed bench for instruction_loader: reset state, basic load with
//   terminator, gapped byte stream, full-memory load, reset mid-word,
//   start while busy and byte_valid while idle/done.

module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [7:0]  new_instruction_address;
    logic        we;
    logic        finish;
    logic        busy;
    logic [8:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  log_addr[$];
    logic [15:0] log_data[$];

    instruction_loader dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .byte_in                 (byte_in),
        .byte_valid              (byte_valid),
        .byte_ready              (byte_ready),
        .instruction_in          (instruction_in),
        .new_instruction_address (new_instruction_address),
        .we                      (we),
        .finish                  (finish),
        .busy                    (busy),
        .word_count              (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            log_addr.push_back(new_instruction_address);
            log_data.push_back(instruction_in);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit seen;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        seen       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (byte_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("byte_ready_timeout", 32'(seen), 32'd1);
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'h5A;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                             input int gap, input logic exp_we);
        send_byte(hi, gap);
        check("we_after_hi", 32'(we), 32'd0);
        send_byte(lo, gap);
        check("we_after_lo", 32'(we), 32'(exp_we));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int bad;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) tick();

        check("rst_we",         32'(we), 32'd0);
        check("rst_finish",     32'(finish), 32'd0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_instr",      32'(instruction_in), 32'd0);
        check("rst_addr",       32'(new_instruction_address), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);

        reset = 1'b0;
        tick();

        // byte_valid in IDLE is ignored
        byte_in    = 8'h12;
        byte_valid = 1'b1;
        repeat (3) tick();
        check("idle_byte_ready", 32'(byte_ready), 32'd0);
        check("idle_busy",       32'(busy), 32'd0);
        check("idle_no_write",   32'(log_addr.size()), 32'd0);
        byte_valid = 1'b0;

        // basic load: 12 34 56 78 FF FF
        clear_log();
        do_start();
        check("t1_busy",  32'(busy), 32'd1);
        check("t1_ready", 32'(byte_ready), 32'd1);
        send_word(8'h12, 8'h34, 0, 1'b1);
        check("t1_w0_addr", 32'(new_instruction_address), 32'h0);
        check("t1_w0_data", 32'(instruction_in), 32'h1234);
        tick();
        check("t1_we_one_cycle", 32'(we), 32'd0);
        send_word(8'h56, 8'h78, 0, 1'b1);
        check("t1_w1_addr", 32'(new_instruction_address), 32'h1);
        check("t1_w1_data", 32'(instruction_in), 32'h5678);
        send_word(8'hFF, 8'hFF, 0, 1'b0);
        check("t1_term_addr_hold", 32'(new_instruction_address), 32'h1);
        tick();
        check("t1_finish",     32'(finish), 32'd1);
        check("t1_busy_done",  32'(busy), 32'd0);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_log_size",   32'(log_addr.size()), 32'd2);

        // byte_valid in DONE is ignored
        byte_in    = 8'h33;
        byte_valid = 1'b1;
        repeat (3) tick();
        check("done_byte_ready", 32'(byte_ready), 32'd0);
        check("done_finish",     32'(finish), 32'd1);
        check("done_no_write",   32'(log_addr.size()), 32'd2);
        byte_valid = 1'b0;

        // gapped stream
        clear_log();
        do_start();
        check("t2_finish_drop", 32'(finish), 32'd0);
        check("t2_wc_clear",    32'(word_count), 32'd0);
        send_word(8'hAB, 8'hCD, 1, 1'b1);
        send_word(8'h01, 8'h02, 1, 1'b1);
        send_word(8'hFF, 8'hFF, 1, 1'b0);
        tick();
        check("t2_log_size",   32'(log_addr.size()), 32'd2);
        check("t2_w0_addr",    32'(log_addr[0]), 32'h0);
        check("t2_w0_data",    32'(log_data[0]), 32'hABCD);
        check("t2_w1_addr",    32'(log_addr[1]), 32'h1);
        check("t2_w1_data",    32'(log_data[1]), 32'h0102);
        check("t2_word_count", 32'(word_count), 32'd2);
        check("t2_finish",     32'(finish), 32'd1);

        // reset after only a high byte
        clear_log();
        do_start();
        send_byte(8'hAA, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t3_busy",       32'(busy), 32'd0);
        check("t3_byte_ready", 32'(byte_ready), 32'd0);
        check("t3_word_count", 32'(word_count), 32'd0);
        tick();
        check("t3_no_write",   32'(log_addr.size()), 32'd0);
        do_start();
        send_word(8'h11, 8'h22, 0, 1'b1);
        check("t3_w0_addr", 32'(new_instruction_address), 32'h0);
        check("t3_w0_data", 32'(instruction_in), 32'h1122);
        send_word(8'hFF, 8'hFF, 0, 1'b0);
        tick();
        check("t3_word_count_end", 32'(word_count), 32'd1);
        check("t3_log_size",       32'(log_addr.size()), 32'd1);

        // start pulsed during LO is ignored
        clear_log();
        do_start();
        send_word(8'h12, 8'h34, 0, 1'b1);
        send_byte(8'h56, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_still_lo_ready", 32'(byte_ready), 32'd1);
        check("t4_busy",           32'(busy), 32'd1);
        send_byte(8'h78, 0);
        check("t4_we",   32'(we), 32'd1);
        check("t4_addr", 32'(new_instruction_address), 32'h1);
        check("t4_data", 32'(instruction_in), 32'h5678);
        send_word(8'hFF, 8'hFF, 0, 1'b0);
        tick();
        check("t4_word_count", 32'(word_count), 32'd2);
        check("t4_finish",     32'(finish), 32'd1);
        do_start();
        check("t4_restart_finish", 32'(finish), 32'd0);
        send_word(8'h9A, 8'hBC, 0, 1'b1);
        check("t4_restart_addr", 32'(new_instruction_address), 32'h0);
        check("t4_restart_data", 32'(instruction_in), 32'h9ABC);
        send_word(8'hFF, 8'hFF, 0, 1'b0);
        tick();

        // full memory: 256 words, no terminator
        clear_log();
        do_start();
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i), ~8'(i), 0, 1'b1);
        end
        check("t5_last_addr", 32'(new_instruction_address), 32'hFF);
        check("t5_last_data", 32'(instruction_in), 32'hFF00);
        tick();
        check("t5_finish",     32'(finish), 32'd1);
        check("t5_busy",       32'(busy), 32'd0);
        check("t5_word_count", 32'(word_count), 32'd256);
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        repeat (3) tick();
        check("t5_257th_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;
        check("t5_log_size", 32'(log_addr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < log_addr.size() && i < 256; i++) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== {8'(i), ~8'(i)}) bad++;
        end
        check("t5_log_contents", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
